bundle_sweep_scheduler: RTL and testbench
=========================================

BUNDLE_SWEEP_SCHEDULER -- requirements
Module: bundle_sweep_scheduler

Interface

Parameters (name, default, meaning)
REQ-001 The block SHALL have parameter HV_ADDRESS_WIDTH, default 20: width of every address, offset and length field.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of cycles spent waiting on one mapper operation.

Ports (name, direction, width, meaning)
REQ-003 The block SHALL have port clk, in, 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, in, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, in, 2: bit i is the command request from requester i.
REQ-006 The block SHALL have port req_ready, out, 2: bit i is the command accept for requester i; combinational.
REQ-007 The block SHALL have ports req_hva, req_hvb and req_hvc, in, 2*HV_ADDRESS_WIDTH: per-requester base addresses, slice i belonging to requester i.
REQ-008 The block SHALL have port req_len, in, 2*HV_ADDRESS_WIDTH: per-requester word count.
REQ-009 The block SHALL have port req_mode, in, 2: per-requester bundling mode.
REQ-010 The block SHALL have port req_done, out, 2: per-requester completion pulse, one cycle wide.
REQ-011 The block SHALL have port req_err, out, 2: per-requester timeout flag, valid only with req_done.
REQ-012 The block SHALL have port m_valid, out, 1: start pulse to the mapper.
REQ-013 The block SHALL have ports m_hva, m_hvb, m_hvc and m_hv_offset, out, HV_ADDRESS_WIDTH: the mapper operand addresses.
REQ-014 The block SHALL have port m_mode, out, 1: the mapper bundling mode.
REQ-015 The block SHALL have port m_done, in, 1: the mapper idle/complete level.
REQ-016 The block SHALL have port busy, out, 1: high in every state except S_IDLE.
REQ-017 The block SHALL have port grant_id, out, 1: index of the requester currently owning the mapper.

Function
REQ-018 Command transfer SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-019 req_ready[i] SHALL be high only in S_IDLE, with req_valid[i] high and requester i winning arbitration.
REQ-020 At most one req_ready bit SHALL be high in any cycle.
REQ-021 Arbitration SHALL be round-robin:
- a lone requester wins;
- when both request, the requester not granted last wins;
- after reset, requester 0 wins a tie.
REQ-022 On transfer, the block SHALL:
- register hva, hvb, hvc, len and mode of the winner into m_hva, m_hvb, m_hvc, a length register and m_mode;
- set grant_id to the winner;
- clear m_hv_offset to 0 and the timeout counter to 0;
- go to S_ISSUE.
REQ-023 Captured fields SHALL stay constant until S_IDLE is re-entered; requester inputs SHALL be ignored during that time.
REQ-024 A command with req_len = 0 SHALL go from S_ISSUE to S_FINISH without asserting m_valid.
REQ-025 In S_ISSUE with m_done high, the block SHALL register m_valid high for exactly one cycle and go to S_WAIT_LO; with m_done low it SHALL stay in S_ISSUE.
REQ-026 In S_WAIT_LO, m_valid SHALL be 0; the block SHALL go to S_WAIT_HI when m_done is sampled low.
REQ-027 In S_WAIT_HI, when m_done is sampled high:
- if m_hv_offset equals len-1, the block SHALL go to S_FINISH;
- otherwise it SHALL increment m_hv_offset by 1 and go to S_ISSUE.
REQ-028 m_hv_offset SHALL count unsigned in HV_ADDRESS_WIDTH bits and never wrap during a legal command (len ≤ 2^HV_ADDRESS_WIDTH-1).
REQ-029 The timeout counter SHALL:
- increment on each cycle spent in S_WAIT_LO or S_WAIT_HI;
- clear on each m_valid.
REQ-030 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL abandon remaining offsets, set an internal error flag and go to S_FINISH.
REQ-031 In S_FINISH, the block SHALL:
- pulse req_done[grant_id] for one cycle, with req_err[grant_id] equal to the error flag;
- record grant_id as last-granted;
- clear the error flag;
- return to S_IDLE.
REQ-032 Minimum command latency SHALL be:
- len = 0: transfer edge to req_done = 2 cycles;
- each word: 3 cycles plus mapper busy time.
REQ-033 A new transfer SHALL be possible on the first cycle after S_FINISH.
REQ-034 All outputs other than req_ready SHALL be registered.

Reset
REQ-035 Assertion of reset_n low, including mid-operation, SHALL immediately put the block in state S_IDLE with:
- m_valid, m_mode, busy, grant_id, req_done and req_err at 0;
- all address and offset outputs at 0;
- last-granted set so that requester 0 wins the next tie;
- error flag and timeout counter at 0.
REQ-036 Any in-flight command SHALL be discarded by reset, with no req_done.

Verification
REQ-037 Single command, req0 hva=0x100, hvb=0x200, hvc=0x300, len=3, mode=0, model mapper 4-cycle busy -> m_valid pulses with m_hv_offset 0,1,2; req_done[0] pulses once; req_err[0]=0.
REQ-038 Both requesters valid in the same cycle after reset, then both again -> first grant to 0, next to 1, req_ready never both high.
REQ-039 req_len=0 -> no m_valid; req_done pulses 2 cycles after transfer.
REQ-040 Mapper holds m_done low forever, TIMEOUT_CYCLES=16 -> req_done with req_err=1 after 16 waiting cycles; block back in S_IDLE.
REQ-041 reset_n low during S_WAIT_HI of a len=5 command -> all outputs 0 and busy=0; no req_done; a subsequent command starts at offset 0.
REQ-042 m_done low on entry to S_ISSUE -> m_valid withheld until m_done returns high.

Source files
------------

// File: rtl/bundle_sweep_scheduler.sv
// Two-requester round-robin scheduler that sweeps a mapper over a word range.
// A granted command drives one mapper operation per offset 0..len-1, waiting on
// the mapper's m_done handshake each time. A watchdog abandons the sweep with an
// error if the mapper stalls.
module bundle_sweep_scheduler #(
  parameter int unsigned HV_ADDRESS_WIDTH = 20,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [2*HV_ADDRESS_WIDTH-1:0] req_hva,
  input  logic [2*HV_ADDRESS_WIDTH-1:0] req_hvb,
  input  logic [2*HV_ADDRESS_WIDTH-1:0] req_hvc,
  input  logic [2*HV_ADDRESS_WIDTH-1:0] req_len,
  input  logic [1:0]                    req_mode,
  output logic [1:0]                    req_done,
  output logic [1:0]                    req_err,
  output logic                          m_valid,
  output logic [HV_ADDRESS_WIDTH-1:0]   m_hva,
  output logic [HV_ADDRESS_WIDTH-1:0]   m_hvb,
  output logic [HV_ADDRESS_WIDTH-1:0]   m_hvc,
  output logic [HV_ADDRESS_WIDTH-1:0]   m_hv_offset,
  output logic                          m_mode,
  input  logic                          m_done,
  output logic                          busy,
  output logic                          grant_id
);

  localparam int unsigned AW = HV_ADDRESS_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitLo, StWaitHi, StFinish} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] hva_q, hva_d, hvb_q, hvb_d, hvc_q, hvc_d;
  logic [AW-1:0] len_q, len_d, off_q, off_d;
  logic          mode_q, mode_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          m_valid_q, m_valid_d;
  logic          busy_q, busy_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    rerr_q, rerr_d;
  logic          winner;

  // Round-robin pick; on a tie the requester not granted last wins.
  always_comb begin
    winner    = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      winner = ~last_q;
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
    if ((state_q == StIdle) && (req_valid != 2'b00)) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Next-state and registered-output logic for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    hva_d     = hva_q;
    hvb_d     = hvb_q;
    hvc_d     = hvc_q;
    len_d     = len_q;
    off_d     = off_q;
    mode_d    = mode_q;
    grant_d   = grant_q;
    last_d    = last_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    m_valid_d = 1'b0;
    done_d    = 2'b00;
    rerr_d    = 2'b00;

    case (state_q)
      StIdle: begin
        if (req_valid != 2'b00) begin
          hva_d   = winner ? req_hva[2*AW-1:AW] : req_hva[AW-1:0];
          hvb_d   = winner ? req_hvb[2*AW-1:AW] : req_hvb[AW-1:0];
          hvc_d   = winner ? req_hvc[2*AW-1:AW] : req_hvc[AW-1:0];
          len_d   = winner ? req_len[2*AW-1:AW] : req_len[AW-1:0];
          mode_d  = req_mode[winner];
          grant_d = winner;
          off_d   = '0;
          tmo_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (len_q == '0) begin
          state_d = StFinish;
        end else if (m_done) begin
          m_valid_d = 1'b1;
          tmo_d     = '0;
          state_d   = StWaitLo;
        end
      end
      StWaitLo: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else if (!m_done) begin
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        tmo_d = tmo_q + 1'b1;
        // A completion seen on the last waiting cycle still counts as success.
        if (m_done) begin
          if (off_q == len_q - AW'(1)) begin
            state_d = StFinish;
          end else begin
            off_d   = off_q + AW'(1);
            state_d = StIssue;
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_d[grant_q] = 1'b1;
        rerr_d[grant_q] = err_q;
        last_d          = grant_q;
        err_d           = 1'b0;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      hva_q     <= '0;
      hvb_q     <= '0;
      hvc_q     <= '0;
      len_q     <= '0;
      off_q     <= '0;
      mode_q    <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 2'b00;
      rerr_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      hva_q     <= hva_d;
      hvb_q     <= hvb_d;
      hvc_q     <= hvc_d;
      len_q     <= len_d;
      off_q     <= off_d;
      mode_q    <= mode_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rerr_q    <= rerr_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_hva       = hva_q;
  assign m_hvb       = hvb_q;
  assign m_hvc       = hvc_q;
  assign m_hv_offset = off_q;
  assign m_mode      = mode_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign req_done    = done_q;
  assign req_err     = rerr_q;

endmodule

// File: tb/tb_bundle_sweep_scheduler.sv
// Bench for bundle_sweep_scheduler: directed scenarios plus randomized traffic
// from two requesters, checked by a transaction-level scoreboard and a model mapper.
module tb_bundle_sweep_scheduler;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 16;

  logic            clk;
  logic            reset_n;
  logic [1:0]      req_valid, req_ready, req_mode, req_done, req_err;
  logic [2*AW-1:0] req_hva, req_hvb, req_hvc, req_len;
  logic            m_valid, m_mode, m_done, busy, grant_id;
  logic [AW-1:0]   m_hva, m_hvb, m_hvc, m_hv_offset;

  // Per-requester driver state
  logic          v0 = 1'b0, v1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
  logic [AW-1:0] hva0 = '0, hvb0 = '0, hvc0 = '0, len0 = '0;
  logic [AW-1:0] hva1 = '0, hvb1 = '0, hvc1 = '0, len1 = '0;

  assign req_valid = {v1, v0};
  assign req_mode  = {mode1, mode0};
  assign req_hva   = {hva1, hva0};
  assign req_hvb   = {hvb1, hvb0};
  assign req_hvc   = {hvc1, hvc0};
  assign req_len   = {len1, len0};

  // Model mapper controls
  int   fixed_busy = 0;
  logic stuck      = 1'b0;
  logic force_low  = 1'b0;

  // Scoreboard state
  int            n_checks = 0, n_fail = 0;
  int            cyc = 0;
  logic          active = 1'b0, last_model = 1'b1, exp_err = 1'b0;
  logic          prev_m_valid = 1'b0, prev_m_done = 1'b1;
  int            owner = 0, c_len = 0, exp_off = 0, issued = 0;
  int            xfer_cyc = 0, mv_cyc = 0;
  logic [AW-1:0] c_hva, c_hvb, c_hvc;
  logic          c_mode;
  int            mv_cnt = 0, err_cnt = 0;
  int            done_cnt [2] = '{0, 0};
  int            grants [$];
  int            mon_w;
  logic [1:0]    mon_rdy;

  bundle_sweep_scheduler #(
    .HV_ADDRESS_WIDTH(AW),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_hva    (req_hva),
    .req_hvb    (req_hvb),
    .req_hvc    (req_hvc),
    .req_len    (req_len),
    .req_mode   (req_mode),
    .req_done   (req_done),
    .req_err    (req_err),
    .m_valid    (m_valid),
    .m_hva      (m_hva),
    .m_hvb      (m_hvb),
    .m_hvc      (m_hvc),
    .m_hv_offset(m_hv_offset),
    .m_mode     (m_mode),
    .m_done     (m_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model mapper: drops m_done for a busy period after each start pulse.
  initial begin
    int b;
    m_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        m_done = 1'b0;
        if (!stuck) begin
          b = (fixed_busy > 0) ? fixed_busy : int'($urandom_range(1, 5));
          repeat (b) @(posedge clk);
          #1;
          m_done = 1'b1;
        end
      end else if (!stuck) begin
        m_done = !force_low;
      end
    end
  end

  // Scoreboard: follows each accepted command at transaction level.
  always @(negedge clk) begin
    if (!reset_n) begin
      active       = 1'b0;
      last_model   = 1'b1;
      prev_m_valid = 1'b0;
      prev_m_done  = m_done;
    end else begin
      if (req_done != 2'b00) begin
        check("done_active", 64'(active), 64'd1);
        check("done_owner", 64'(req_done), 64'(2'b01 << owner));
        check("done_err", 64'(req_err), exp_err ? 64'(2'b01 << owner) : 64'd0);
        if (exp_err) check("tmo_latency", 64'(cyc - mv_cyc), 64'(TMO + 1));
        else         check("done_words", 64'(issued), 64'(c_len));
        if (c_len == 0) check("len0_latency", 64'(cyc - xfer_cyc), 64'd2);
        done_cnt[owner]++;
        if (req_err != 2'b00) err_cnt++;
        active     = 1'b0;
        last_model = (owner == 1);
      end

      mon_rdy = 2'b00;
      if (!active && req_valid != 2'b00) begin
        if (req_valid == 2'b11) mon_w = last_model ? 0 : 1;
        else                    mon_w = req_valid[1] ? 1 : 0;
        mon_rdy[mon_w] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(mon_rdy));
      check("busy", 64'(busy), 64'(active));

      if (m_valid) begin
        check("mv_active", 64'(active), 64'd1);
        check("mv_pulse", 64'(prev_m_valid), 64'd0);
        check("mv_gate", 64'(prev_m_done), 64'd1);
        check("mv_in_len", 64'(exp_off < c_len), 64'd1);
        check("m_hv_offset", 64'(m_hv_offset), 64'(exp_off));
        check("m_hva", 64'(m_hva), 64'(c_hva));
        check("m_hvb", 64'(m_hvb), 64'(c_hvb));
        check("m_hvc", 64'(m_hvc), 64'(c_hvc));
        check("m_mode", 64'(m_mode), 64'(c_mode));
        check("grant_id", 64'(grant_id), 64'(owner));
        exp_off++;
        issued++;
        mv_cnt++;
        mv_cyc = cyc;
      end

      if ((req_valid & req_ready) != 2'b00) begin
        mon_w    = req_ready[1] ? 1 : 0;
        owner    = mon_w;
        c_hva    = mon_w ? hva1 : hva0;
        c_hvb    = mon_w ? hvb1 : hvb0;
        c_hvc    = mon_w ? hvc1 : hvc0;
        c_len    = int'(mon_w ? len1 : len0);
        c_mode   = mon_w ? mode1 : mode0;
        active   = 1'b1;
        exp_off  = 0;
        issued   = 0;
        xfer_cyc = cyc + 1;
        grants.push_back(mon_w);
      end

      prev_m_valid = m_valid;
      prev_m_done  = m_done;
    end
  end

  task automatic issue(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic [AW-1:0] l, input logic md);
    int n;
    n = 0;
    if (i == 0) begin
      hva0 = a; hvb0 = b; hvc0 = c; len0 = l; mode0 = md; v0 = 1'b1;
    end else begin
      hva1 = a; hvb1 = b; hvc1 = c; len1 = l; mode1 = md; v1 = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 1000);
    check("accepted", 64'(req_ready[i]), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the captured command must not change.
    if (i == 0) begin
      v0 = 1'b0; hva0 = AW'($urandom); hvb0 = AW'($urandom); hvc0 = AW'($urandom);
      len0 = AW'($urandom); mode0 = 1'($urandom);
    end else begin
      v1 = 1'b0; hva1 = AW'($urandom); hvb1 = AW'($urandom); hvc1 = AW'($urandom);
      len1 = AW'($urandom); mode1 = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    check("idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      issue(i, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)));
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({m_valid, m_mode, busy, grant_id, req_done, req_err,
                m_hva, m_hvb, m_hvc, m_hv_offset});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv0, d0, d1, e0, n;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", out_vec(), 64'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests after reset: 0, then 1, then 0, then 1.
    grants.delete();
    fork
      issue(0, AW'('h11), AW'('h12), AW'('h13), AW'(2), 1'b1);
      issue(1, AW'('h21), AW'('h22), AW'('h23), AW'(1), 1'b0);
    join
    fork
      issue(0, AW'('h31), AW'('h32), AW'('h33), AW'(1), 1'b0);
      issue(1, AW'('h41), AW'('h42), AW'('h43), AW'(2), 1'b1);
    join
    wait_idle();
    check("tie_count", 64'(grants.size()), 64'd4);
    if (grants.size() >= 4) begin
      check("tie_g0", 64'(grants[0]), 64'd0);
      check("tie_g1", 64'(grants[1]), 64'd1);
      check("tie_g2", 64'(grants[2]), 64'd0);
      check("tie_g3", 64'(grants[3]), 64'd1);
    end

    // Single three-word command with a 4-cycle mapper.
    fixed_busy = 4;
    mv0 = mv_cnt; d0 = done_cnt[0];
    issue(0, AW'('h100), AW'('h200), AW'('h300), AW'(3), 1'b0);
    wait_idle();
    check("single_mv", 64'(mv_cnt - mv0), 64'd3);
    check("single_done", 64'(done_cnt[0] - d0), 64'd1);
    fixed_busy = 0;

    // Zero-length command.
    mv0 = mv_cnt; d1 = done_cnt[1];
    issue(1, AW'('h5), AW'('h6), AW'('h7), AW'(0), 1'b1);
    wait_idle();
    check("len0_mv", 64'(mv_cnt - mv0), 64'd0);
    check("len0_done", 64'(done_cnt[1] - d1), 64'd1);

    // Mapper not ready on issue: start pulse must be withheld.
    force_low = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    mv0 = mv_cnt;
    issue(0, AW'('h50), AW'('h60), AW'('h70), AW'(1), 1'b1);
    repeat (6) @(negedge clk);
    check("hold_mv", 64'(mv_cnt - mv0), 64'd0);
    force_low = 1'b0;
    wait_idle();
    check("hold_release_mv", 64'(mv_cnt - mv0), 64'd1);

    // Stalled mapper: timeout with error.
    stuck = 1'b1; exp_err = 1'b1;
    mv0 = mv_cnt; e0 = err_cnt;
    issue(1, AW'('h80), AW'('h90), AW'('ha0), AW'(3), 1'b0);
    wait_idle();
    check("tmo_err", 64'(err_cnt - e0), 64'd1);
    check("tmo_mv", 64'(mv_cnt - mv0), 64'd1);
    stuck = 1'b0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting on the mapper in the middle of a five-word command.
    fixed_busy = 6;
    mv0 = mv_cnt;
    issue(0, AW'('hb0), AW'('hc0), AW'('hd0), AW'(5), 1'b1);
    n = 0;
    while ((mv_cnt - mv0) < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach", 64'(mv_cnt - mv0), 64'd2);
    repeat (3) @(posedge clk);
    #2;
    d0 = done_cnt[0] + done_cnt[1];
    reset_n = 1'b0;
    #1;
    check("midrst_outs", out_vec(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_nodone", 64'(done_cnt[0] + done_cnt[1] - d0), 64'd0);
    fixed_busy = 0;
    mv0 = mv_cnt;
    issue(1, AW'('he0), AW'('hf0), AW'('h1f0), AW'(2), 1'b0);
    wait_idle();
    check("post_rst_mv", 64'(mv_cnt - mv0), 64'd2);
    check("post_rst_done", 64'(done_cnt[0] + done_cnt[1] - d0), 64'd1);

    // Randomized traffic from both requesters.
    fork
      drive(0, 25);
      drive(1, 25);
    join
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
